// File: rtl/cmp_result_checker_if.sv
// Operand/result taps of a priority comparator plus the run statistics
// reported by the checker that scores it.
interface cmp_result_checker_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
);
    logic               start;
    logic               sample_valid;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               Y2;
    logic               Y1;
    logic               Y0;
    logic               busy;
    logic               done;
    logic               err;
    logic [CNT_W-1:0]   pass_cnt;
    logic [CNT_W-1:0]   fail_cnt;
    logic [CNT_W-1:0]   viol_cnt;
    logic [2*WIDTH+5:0] first_fail;

    modport master (
        output start, sample_valid, A, B, Y2, Y1, Y0,
        input  busy, done, err, pass_cnt, fail_cnt, viol_cnt, first_fail
    );

    modport slave (
        input  start, sample_valid, A, B, Y2, Y1, Y0,
        output busy, done, err, pass_cnt, fail_cnt, viol_cnt, first_fail
    );
endinterface

// File: rtl/cmp_result_checker.sv
// Scoreboard beside a pipelined priority comparator: delays a locally computed
// expected result by the comparator latency and scores each returned result.
module cmp_result_checker #(
    parameter int WIDTH       = 4,
    parameter int LATENCY     = 1,
    parameter int NUM_SAMPLES = 100,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    cmp_result_checker_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int LW  = 2*WIDTH + 4;
    localparam int FFW = 2*WIDTH + 6;
    localparam int SCW = $clog2(NUM_SAMPLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [2:0] expected_code(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (a > b)       expected_code = 3'b100;
        else if (a == b) expected_code = 3'b010;
        else             expected_code = 3'b001;
    endfunction

    function automatic logic is_one_hot(input logic [2:0] y);
        is_one_hot = (y == 3'b100) || (y == 3'b010) || (y == 3'b001);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        sat_inc = (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    state_t           r_state, w_state_nxt;
    logic [LW-1:0]    r_line [LATENCY];
    logic [SCW-1:0]   r_sample_cnt;
    logic [2:0]       r_drain_cnt;
    logic             r_busy, r_done, r_err;
    logic             w_busy_nxt, w_done_nxt, w_err_nxt;
    logic [CNT_W-1:0] r_pass_cnt, r_fail_cnt, r_viol_cnt;
    logic [CNT_W-1:0] w_pass_nxt, w_fail_nxt, w_viol_nxt;
    logic [FFW-1:0]   r_first_fail, w_first_fail_nxt;
    logic             w_start_ok, w_push_valid, w_last_push, w_score;
    logic [LW-1:0]    w_push, w_line_out;
    logic             w_d_valid;
    logic [WIDTH-1:0] w_d_a, w_d_b;
    logic [2:0]       w_d_exp, w_actual;

    assign w_start_ok   = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_push_valid = (r_state == S_RUN) && bus.sample_valid;
    assign w_last_push  = w_push_valid && (r_sample_cnt == SCW'(NUM_SAMPLES - 1));
    assign w_push       = {w_push_valid, bus.A, bus.B, expected_code(bus.A, bus.B)};
    assign w_line_out   = r_line[LATENCY-1];
    assign {w_d_valid, w_d_a, w_d_b, w_d_exp} = w_line_out;
    assign w_actual     = {bus.Y2, bus.Y1, bus.Y0};
    assign w_score      = w_d_valid && ((r_state == S_RUN) || (r_state == S_DRAIN));

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; start is honoured only from IDLE or DONE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_RUN; else w_state_nxt = S_IDLE;
            S_RUN:   if (w_last_push) w_state_nxt = S_DRAIN; else w_state_nxt = S_RUN;
            S_DRAIN: if (r_drain_cnt == 3'(LATENCY - 1)) w_state_nxt = S_DONE; else w_state_nxt = S_DRAIN;
            S_DONE:  if (bus.start) w_state_nxt = S_RUN; else w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so status flags come straight from flops
    always_comb begin
        w_busy_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
        w_done_nxt = (w_state_nxt == S_DONE);
        w_err_nxt  = (w_state_nxt == S_DONE) && (w_fail_nxt != {CNT_W{1'b0}});
    end

    // Expected-result delay line, aligned per cycle rather than per sample
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) r_line[i] <= {LW{1'b0}};
        end else begin
            r_line[0] <= w_push;
            for (int i = 1; i < LATENCY; i++) r_line[i] <= r_line[i-1];
        end
    end

    // Accepted-sample and drain counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample_cnt <= {SCW{1'b0}};
            r_drain_cnt  <= 3'd0;
        end else begin
            if (w_start_ok)        r_sample_cnt <= {SCW{1'b0}};
            else if (w_push_valid) r_sample_cnt <= r_sample_cnt + SCW'(1);
            else                   r_sample_cnt <= r_sample_cnt;
            if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt + 3'd1;
            else                    r_drain_cnt <= 3'd0;
        end
    end

    // Scoring: a non-one-hot result is both a violation and a mismatch
    always_comb begin
        w_pass_nxt       = r_pass_cnt;
        w_fail_nxt       = r_fail_cnt;
        w_viol_nxt       = r_viol_cnt;
        w_first_fail_nxt = r_first_fail;
        if (w_start_ok) begin
            w_pass_nxt       = {CNT_W{1'b0}};
            w_fail_nxt       = {CNT_W{1'b0}};
            w_viol_nxt       = {CNT_W{1'b0}};
            w_first_fail_nxt = {FFW{1'b0}};
        end else if (w_score) begin
            if (w_actual == w_d_exp) begin
                w_pass_nxt = sat_inc(r_pass_cnt);
            end else begin
                w_fail_nxt = sat_inc(r_fail_cnt);
                if (r_fail_cnt == {CNT_W{1'b0}}) w_first_fail_nxt = {w_d_a, w_d_b, w_d_exp, w_actual};
                else                             w_first_fail_nxt = r_first_fail;
            end
            if (!is_one_hot(w_actual)) w_viol_nxt = sat_inc(r_viol_cnt);
            else                       w_viol_nxt = r_viol_cnt;
        end else begin
            w_pass_nxt = r_pass_cnt;
        end
    end

    // Statistics and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pass_cnt   <= {CNT_W{1'b0}};
            r_fail_cnt   <= {CNT_W{1'b0}};
            r_viol_cnt   <= {CNT_W{1'b0}};
            r_first_fail <= {FFW{1'b0}};
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_pass_cnt   <= w_pass_nxt;
            r_fail_cnt   <= w_fail_nxt;
            r_viol_cnt   <= w_viol_nxt;
            r_first_fail <= w_first_fail_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.pass_cnt   = r_pass_cnt;
    assign bus.fail_cnt   = r_fail_cnt;
    assign bus.viol_cnt   = r_viol_cnt;
    assign bus.first_fail = r_first_fail;
endmodule

// File: tb/tb_cmp_result_checker.sv
// Randomized bench: a behavioural comparator (with selectable faults) feeds three
// checker instances; expected statistics come from a list of accepted samples.
module tb_cmp_result_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [3:0] tb_a = 4'h0, tb_b = 4'h0;
    logic       tb_sv = 1'b0, tb_y2 = 1'b0, tb_y1 = 1'b0, tb_y0 = 1'b0;
    logic       st_a = 1'b0, st_b = 1'b0, st_c = 1'b0;

    cmp_result_checker_if #(.WIDTH(4), .CNT_W(16)) ifa ();
    cmp_result_checker_if #(.WIDTH(4), .CNT_W(16)) ifb ();
    cmp_result_checker_if #(.WIDTH(4), .CNT_W(4))  ifc ();

    assign ifa.start = st_a; assign ifa.sample_valid = tb_sv; assign ifa.A = tb_a; assign ifa.B = tb_b;
    assign ifa.Y2 = tb_y2;   assign ifa.Y1 = tb_y1;           assign ifa.Y0 = tb_y0;
    assign ifb.start = st_b; assign ifb.sample_valid = tb_sv; assign ifb.A = tb_a; assign ifb.B = tb_b;
    assign ifb.Y2 = tb_y2;   assign ifb.Y1 = tb_y1;           assign ifb.Y0 = tb_y0;
    assign ifc.start = st_c; assign ifc.sample_valid = tb_sv; assign ifc.A = tb_a; assign ifc.B = tb_b;
    assign ifc.Y2 = tb_y2;   assign ifc.Y1 = tb_y1;           assign ifc.Y0 = tb_y0;

    cmp_result_checker #(.WIDTH(4), .LATENCY(1), .NUM_SAMPLES(100), .CNT_W(16))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    cmp_result_checker #(.WIDTH(4), .LATENCY(1), .NUM_SAMPLES(10), .CNT_W(16))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));
    cmp_result_checker #(.WIDTH(4), .LATENCY(1), .NUM_SAMPLES(20), .CNT_W(4))
        dut_c (.clk(clk), .rst(rst), .bus(ifc));

    typedef struct { logic [3:0] a; logic [3:0] b; logic [2:0] act; } smp_t;
    typedef struct { logic [3:0] a; logic [3:0] b; } pair_t;

    int total = 0, bad = 0;
    int mode = 0;
    smp_t  q[$];
    pair_t stim[$];
    int m_pass, m_fail, m_viol;
    logic [13:0] m_ff;
    logic snap_busy0, snap_done0;
    logic [15:0] snap_fail0, snap_fail_mid;

    function automatic logic [2:0] golden(input logic [3:0] a, input logic [3:0] b);
        if (a > b) return 3'b100;
        if (a == b) return 3'b010;
        return 3'b001;
    endfunction

    // Comparator result as the faulty/golden comparator would produce it
    function automatic logic [2:0] act_fn(input logic [3:0] a, input logic [3:0] b);
        logic [2:0] e;
        e = golden(a, b);
        case (mode)
            1: return e & 3'b101;
            2: return (a == 4'h9 && b == 4'h3) ? 3'b101 : e;
            3: return {e[0], e[2], e[1]};
            default: return e;
        endcase
    endfunction

    function automatic logic busy_of(input int w);
        case (w) 0: return ifa.busy; 1: return ifb.busy; default: return ifc.busy; endcase
    endfunction
    function automatic logic done_of(input int w);
        case (w) 0: return ifa.done; 1: return ifb.done; default: return ifc.done; endcase
    endfunction
    function automatic logic err_of(input int w);
        case (w) 0: return ifa.err; 1: return ifb.err; default: return ifc.err; endcase
    endfunction
    function automatic logic [15:0] pass_of(input int w);
        case (w) 0: return ifa.pass_cnt; 1: return ifb.pass_cnt; default: return 16'(ifc.pass_cnt); endcase
    endfunction
    function automatic logic [15:0] fail_of(input int w);
        case (w) 0: return ifa.fail_cnt; 1: return ifb.fail_cnt; default: return 16'(ifc.fail_cnt); endcase
    endfunction
    function automatic logic [15:0] viol_of(input int w);
        case (w) 0: return ifa.viol_cnt; 1: return ifb.viol_cnt; default: return 16'(ifc.viol_cnt); endcase
    endfunction
    function automatic logic [13:0] ff_of(input int w);
        case (w) 0: return ifa.first_fail; 1: return ifb.first_fail; default: return ifc.first_fail; endcase
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w) 0: st_a = v; 1: st_b = v; default: st_c = v; endcase
    endtask

    // One clock: present last cycle's comparator result and this cycle's operands
    task automatic drive(input logic sv, input logic [3:0] a, input logic [3:0] b);
        {tb_y2, tb_y1, tb_y0} = act_fn(tb_a, tb_b);
        tb_a = a; tb_b = b; tb_sv = sv;
        @(posedge clk); #1;
    endtask

    // Reference statistics over the accepted samples, saturated to cw bits
    task automatic model(input int cw);
        int mx;
        logic [2:0] e;
        mx = (1 << cw) - 1;
        m_pass = 0; m_fail = 0; m_viol = 0; m_ff = 14'h0;
        foreach (q[i]) begin
            e = golden(q[i].a, q[i].b);
            if (q[i].act == e) m_pass++;
            else begin
                if (m_fail == 0) m_ff = {q[i].a, q[i].b, e, q[i].act};
                m_fail++;
            end
            if ($countones(q[i].act) != 1) m_viol++;
        end
        if (m_pass > mx) m_pass = mx;
        if (m_fail > mx) m_fail = mx;
        if (m_viol > mx) m_viol = mx;
    endtask

    // One run on checker w; k counts cycles from RUN entry
    task automatic run(input int w, input int ns, input bit alt, input int abort_n,
                       input int mid_k, output int done_k, output int last_k);
        int k;
        logic sv;
        logic [3:0] a, b;
        pair_t p;
        k = 0; q.delete(); done_k = -1; last_k = -1;
        set_start(w, 1'b1); drive(1'b0, 4'h0, 4'h0); set_start(w, 1'b0);
        while (k < 400) begin
            if (k == 0) begin
                snap_busy0 = busy_of(w); snap_done0 = done_of(w); snap_fail0 = fail_of(w);
            end
            if (mid_k >= 0 && k == mid_k + 2) snap_fail_mid = fail_of(w);
            if (done_of(w)) begin done_k = k; break; end
            if (abort_n > 0 && q.size() == abort_n) begin
                rst = 1'b1; drive(1'b0, 4'h0, 4'h0); rst = 1'b0;
                done_k = -2;
                return;
            end
            sv = alt ? ((k % 2) == 0) : 1'b1;
            a = 4'($urandom); b = 4'($urandom);
            if (sv && stim.size() > 0) begin p = stim.pop_front(); a = p.a; b = p.b; end
            if (sv && q.size() < ns) begin q.push_back('{a, b, act_fn(a, b)}); last_k = k; end
            if (k == mid_k) set_start(w, 1'b1);
            drive(sv, a, b);
            set_start(w, 1'b0);
            k++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; repeat (3) drive(1'b0, 4'h0, 4'h0); rst = 1'b0;
        for (int w = 0; w < 3; w++) begin
            total++; if (busy_of(w) !== 1'b0 || done_of(w) !== 1'b0 || err_of(w) !== 1'b0) begin
                bad++; $display("FAIL reset_flags dut%0d busy=%b done=%b err=%b exp 0", w, busy_of(w), done_of(w), err_of(w)); end
            total++; if (pass_of(w) !== 16'h0 || fail_of(w) !== 16'h0 || viol_of(w) !== 16'h0 || ff_of(w) !== 14'h0) begin
                bad++; $display("FAIL reset_counts dut%0d pass=%0d fail=%0d viol=%0d ff=%h exp 0", w, pass_of(w), fail_of(w), viol_of(w), ff_of(w)); end
        end
    endtask

    task automatic test_golden();
        int dk, lk;
        mode = 0; stim.delete();
        run(0, 100, 1'b0, 0, -1, dk, lk); model(16);
        total++; if (dk != 101) begin bad++; $display("FAIL golden_done_cycle got=%0d exp=101", dk); end
        total++; if (pass_of(0) !== 16'(m_pass) || m_pass != 100) begin bad++; $display("FAIL golden_pass got=%0d exp=%0d", pass_of(0), m_pass); end
        total++; if (fail_of(0) !== 16'(m_fail) || viol_of(0) !== 16'(m_viol)) begin
            bad++; $display("FAIL golden_fail_viol got=%0d/%0d exp=%0d/%0d", fail_of(0), viol_of(0), m_fail, m_viol); end
        total++; if (err_of(0) !== 1'b0 || busy_of(0) !== 1'b0) begin bad++; $display("FAIL golden_err_busy got=%b/%b exp 0/0", err_of(0), busy_of(0)); end
    endtask

    task automatic test_missing_eq();
        int dk, lk;
        pair_t p;
        mode = 1; stim.delete();
        stim.push_back('{4'h7, 4'h7});
        while (stim.size() < 100) begin
            p.a = 4'($urandom); p.b = 4'($urandom);
            if (p.a != p.b) stim.push_back(p);
        end
        run(0, 100, 1'b0, 0, -1, dk, lk); model(16);
        total++; if (fail_of(0) !== 16'(m_fail) || fail_of(0) !== 16'd1) begin bad++; $display("FAIL eq_fail got=%0d exp=%0d", fail_of(0), m_fail); end
        total++; if (viol_of(0) !== 16'(m_viol) || pass_of(0) !== 16'(m_pass)) begin
            bad++; $display("FAIL eq_viol_pass got=%0d/%0d exp=%0d/%0d", viol_of(0), pass_of(0), m_viol, m_pass); end
        total++; if (ff_of(0) !== {4'h7, 4'h7, 3'b010, 3'b000}) begin bad++; $display("FAIL eq_first_fail got=%h exp=%h", ff_of(0), {4'h7, 4'h7, 3'b010, 3'b000}); end
        total++; if (err_of(0) !== 1'b1 || done_of(0) !== 1'b1) begin bad++; $display("FAIL eq_err_done got=%b/%b exp 1/1", err_of(0), done_of(0)); end
    endtask

    task automatic test_multi_hot();
        int dk, lk;
        pair_t p;
        mode = 2; stim.delete();
        while (stim.size() < 100) begin
            p.a = 4'($urandom); p.b = 4'($urandom);
            if (stim.size() == 5) stim.push_back('{4'h9, 4'h3});
            else if (!(p.a == 4'h9 && p.b == 4'h3)) stim.push_back(p);
        end
        run(0, 100, 1'b0, 0, -1, dk, lk); model(16);
        total++; if (fail_of(0) !== 16'(m_fail) || viol_of(0) !== 16'(m_viol)) begin
            bad++; $display("FAIL mh_fail_viol got=%0d/%0d exp=%0d/%0d", fail_of(0), viol_of(0), m_fail, m_viol); end
        total++; if (ff_of(0) !== {4'h9, 4'h3, 3'b100, 3'b101}) begin bad++; $display("FAIL mh_first_fail got=%h exp=%h", ff_of(0), {4'h9, 4'h3, 3'b100, 3'b101}); end
        total++; if (pass_of(0) !== 16'(m_pass)) begin bad++; $display("FAIL mh_pass got=%0d exp=%0d", pass_of(0), m_pass); end
    endtask

    task automatic test_gapped();
        int dk, lk;
        mode = 0; stim.delete();
        run(1, 10, 1'b1, 0, -1, dk, lk); model(16);
        total++; if (dk != 20 || dk != lk + 2) begin bad++; $display("FAIL gap_done_cycle got=%0d exp=20 (last accept %0d)", dk, lk); end
        total++; if (pass_of(1) !== 16'(m_pass) || m_pass != 10 || fail_of(1) !== 16'h0) begin
            bad++; $display("FAIL gap_counts got=%0d/%0d exp=%0d/0", pass_of(1), fail_of(1), m_pass); end
    endtask

    task automatic test_mid_reset();
        int dk, lk;
        mode = 0; stim.delete();
        run(0, 100, 1'b0, 40, -1, dk, lk);
        total++; if (busy_of(0) !== 1'b0 || done_of(0) !== 1'b0) begin bad++; $display("FAIL rst_mid_flags got=%b/%b exp 0/0", busy_of(0), done_of(0)); end
        total++; if (pass_of(0) !== 16'h0 || fail_of(0) !== 16'h0 || viol_of(0) !== 16'h0) begin
            bad++; $display("FAIL rst_mid_counts got=%0d/%0d/%0d exp 0", pass_of(0), fail_of(0), viol_of(0)); end
        run(0, 100, 1'b0, 0, -1, dk, lk); model(16);
        total++; if (dk != 101 || pass_of(0) !== 16'(m_pass) || fail_of(0) !== 16'h0) begin
            bad++; $display("FAIL rst_rerun got done=%0d pass=%0d fail=%0d exp 101/%0d/0", dk, pass_of(0), fail_of(0), m_pass); end
    endtask

    task automatic test_saturate();
        int dk, lk;
        mode = 3; stim.delete();
        run(2, 20, 1'b0, 0, 5, dk, lk); model(4);
        total++; if (snap_fail_mid !== 16'd6) begin bad++; $display("FAIL sat_start_ignored got=%0d exp=6", snap_fail_mid); end
        total++; if (dk != 21) begin bad++; $display("FAIL sat_done_cycle got=%0d exp=21", dk); end
        total++; if (fail_of(2) !== 16'(m_fail) || m_fail != 15 || pass_of(2) !== 16'h0 || err_of(2) !== 1'b1) begin
            bad++; $display("FAIL sat_fail got fail=%0d pass=%0d err=%b exp %0d/0/1", fail_of(2), pass_of(2), err_of(2), m_fail); end
        mode = 0;
        run(2, 20, 1'b0, 0, -1, dk, lk); model(4);
        total++; if (snap_busy0 !== 1'b1 || snap_done0 !== 1'b0 || snap_fail0 !== 16'h0) begin
            bad++; $display("FAIL sat_restart got busy=%b done=%b fail=%0d exp 1/0/0", snap_busy0, snap_done0, snap_fail0); end
        total++; if (pass_of(2) !== 16'(m_pass) || m_pass != 15 || fail_of(2) !== 16'h0 || err_of(2) !== 1'b0) begin
            bad++; $display("FAIL sat_pass got pass=%0d fail=%0d err=%b exp %0d/0/0", pass_of(2), fail_of(2), err_of(2), m_pass); end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_golden();
        test_missing_eq();
        test_multi_hot();
        test_gapped();
        test_mid_reset();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cmp_result_checker.md
Name: cmp_result_checker

Overview:
- Receiving end of the 4-bit priority comparator interface: drives nothing into the comparator, sits beside it, and checks every result it produces.
- Takes the same operand pair A/B the comparator sees, plus the comparator's registered one-hot result Y2/Y1/Y0.
- Delays a locally computed expected result by the comparator's pipeline latency, then scores pass/fail, one-hot violations and first-failure capture over a run of NUM_SAMPLES operand pairs.
- Used as an on-chip self-check beside the comparator and as the scoreboard in its benches.

Parameters:
WIDTH, 4, operand width of A and B
LATENCY, 1, cycles from operand applied to result on Y2/Y1/Y0; legal range 1..4
NUM_SAMPLES, 100, valid operand pairs accepted per run
CNT_W, 16, width of each statistics counter

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a run from IDLE or DONE
sample_valid  in  1  A/B this cycle are a valid operand pair
A  in  WIDTH  operand A as presented to comparator
B  in  WIDTH  operand B as presented to comparator
Y2  in  1  comparator result: A > B
Y1  in  1  comparator result: A == B
Y0  in  1  comparator result: A < B
busy  out  1  run in progress (RUN or DRAIN)
done  out  1  run complete, statistics stable
err  out  1  fail_cnt != 0, valid while done=1
pass_cnt  out  CNT_W  results matching expectation
fail_cnt  out  CNT_W  results not matching expectation
viol_cnt  out  CNT_W  results not exactly one-hot
first_fail  out  2*WIDTH+6  {A, B, expected[2:0], actual[2:0]} of first failure

Behaviour:
- Reset (rst=1 at clk edge, any state): state=IDLE; busy, done, err, all counters, first_fail, delay-line valid bits and sample counter cleared to 0. Reset mid-run abandons the run with no partial done.
- Expected encoding is {Y2,Y1,Y0}: 3'b100 if A>B, 3'b010 if A==B, 3'b001 if A<B, unsigned compare.
- FSM states:
  - IDLE: wait for start.
  - RUN: accept samples.
  - DRAIN: flush LATENCY cycles.
  - DONE: hold results.
- start in IDLE or DONE: next cycle state=RUN, busy=1, done=0, counters/first_fail/sample count cleared. start during RUN/DRAIN is ignored.
- RUN:
  - Each cycle with sample_valid=1, push {A, B, expected, valid=1} into a LATENCY-deep shift line; otherwise push valid=0.
  - Increment the accepted count on each push with valid=1.
  - On the cycle the NUM_SAMPLES-th pair is accepted, go to DRAIN. Further sample_valid is ignored.
- Scoring: on any cycle (RUN or DRAIN) where the line output valid=1, compare actual={Y2,Y1,Y0} to the delayed expected.
  - Equal: pass_cnt+1.
  - Unequal: fail_cnt+1. If fail_cnt was 0, latch first_fail with the delayed A, B, expected and the current actual.
  - Independently, if actual is 000 or has >1 bit set: viol_cnt+1. A violation always also counts as a fail.
  - Cycles whose line output valid=0 are not scored.
- DRAIN: lasts exactly LATENCY cycles so the last sample is scored, then go to DONE.
- DONE: busy=0, done=1, err=(fail_cnt!=0). Outputs hold until start or rst.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Invariant at done: pass_cnt + fail_cnt = NUM_SAMPLES, unless a counter saturated.
- sample_valid gaps are allowed; the delay line keeps alignment per cycle, not per sample.

Test Plan:
1. Golden comparator model (LATENCY=1, NUM_SAMPLES=100), random A/B with sample_valid=1 every cycle, start pulse -> done=1 exactly 101 cycles after RUN entry; pass_cnt=100, fail_cnt=0, viol_cnt=0, err=0.
2. Y1 forced 0, A=B=4'h7 as first sample, remaining samples unequal -> fail_cnt=1, viol_cnt=1 (actual 000), first_fail={4'h7,4'h7,3'b010,3'b000}, err=1.
3. Multi-hot fault: Y2 and Y0 both 1 for A=4'h9, B=4'h3 -> fail_cnt+1, viol_cnt+1, expected field 3'b100, actual 3'b101.
4. sample_valid toggled 1,0,1,0… with NUM_SAMPLES=10 -> exactly 10 scored results, pass_cnt=10, done 1 cycle after the 10th accepted sample's result is scored.
5. rst=1 asserted mid-RUN after 40 samples -> next cycle busy=0, done=0, all counters 0. A new start then gives a clean 100-sample run.
6. CNT_W=4, NUM_SAMPLES=20, all-fail model -> fail_cnt saturates at 15. start during RUN is ignored and counters are not cleared. start in DONE restarts with zeroed counters.
